// File: rtl/bellek_erisim.sv
// Memory-access stage: pass-through of execute results, aligned load/store handshake, byte-lane steering.
// Optional memory timeout abort enabled by defining BELLEK_ZAMAN_ASIMI_EN.
module bellek_erisim (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        durdur_i,
    input  logic        gecerli_i,
    input  logic        bellek_i,
    input  logic [3:0]  islem_i,
    input  logic [31:0] adres_i,
    input  logic [31:0] veri_i,
    input  logic [4:0]  rd_i,
    output logic        mem_istek_o,
    output logic        mem_yaz_o,
    output logic [31:0] mem_adres_o,
    output logic [31:0] mem_veri_o,
    output logic [3:0]  mem_maske_o,
    input  logic        mem_hazir_i,
    input  logic [31:0] mem_veri_i,
    output logic        gecerli_o,
    output logic [31:0] sonuc_o,
    output logic [4:0]  rd_o,
    output logic        yaz_o,
    output logic [1:0]  hata_o,
    output logic        durdur_o
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 4;

    typedef enum logic [0:0] {BOSTA, ISTEK} durum_t;

    durum_t            durum_q, durum_d;
    logic [XLEN-1:0]   adres_q, adres_d, veri_q, veri_d, sonuc_q, sonuc_d;
    logic [OPW-1:0]    islem_q, islem_d;
    logic [RW-1:0]     rd_q, rd_d, rd_o_q, rd_o_d;
    logic              gecerli_q, gecerli_d, yaz_q, yaz_d, hizasiz_q, hizasiz_d;
`ifdef BELLEK_ZAMAN_ASIMI_EN
    localparam int unsigned SAYAC_W = 8;
    // Counter value at the 255th ISTEK cycle without a transfer.
    localparam logic [SAYAC_W-1:0] ZAMAN_SINIRI = SAYAC_W'(254);
    logic [SAYAC_W-1:0] sayac_q, sayac_d;
    logic               zaman_q, zaman_d;
`endif

    logic            istekte_c, aktarim_c, tut_c, hizali_c;
    logic [7:0]      bayt_c;
    logic [15:0]     yarim_c;
    logic [XLEN-1:0] yuk_c;

    assign istekte_c = (durum_q == ISTEK);
    assign aktarim_c = istekte_c && !durdur_i && mem_hazir_i;
    assign tut_c     = gecerli_q && durdur_i;

    // Alignment of the incoming op: byte always, half needs bit 0 clear, word needs both clear.
    always_comb begin
        hizali_c = 1'b1;
        case (islem_i[1:0])
            2'b00:   hizali_c = 1'b1;
            2'b01:   hizali_c = !adres_i[0];
            default: hizali_c = (adres_i[1:0] == 2'b00);
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        bayt_c  = 8'(mem_veri_i >> {adres_q[1:0], 3'b000});
        yarim_c = adres_q[1] ? mem_veri_i[31:16] : mem_veri_i[15:0];
        case (islem_q[1:0])
            2'b00:   yuk_c = islem_q[2] ? {24'b0, bayt_c}  : {{24{bayt_c[7]}}, bayt_c};
            2'b01:   yuk_c = islem_q[2] ? {16'b0, yarim_c} : {{16{yarim_c[15]}}, yarim_c};
            default: yuk_c = mem_veri_i;
        endcase
    end

    // Store lane steering; the mask only drives while a store is outstanding.
    always_comb begin
        mem_veri_o  = veri_q;
        mem_maske_o = 4'b0000;
        case (islem_q[1:0])
            2'b00: begin
                mem_veri_o  = {4{veri_q[7:0]}};
                mem_maske_o = 4'(4'b0001 << adres_q[1:0]);
            end
            2'b01: begin
                mem_veri_o  = {2{veri_q[15:0]}};
                mem_maske_o = 4'(4'b0011 << adres_q[1:0]);
            end
            default: mem_maske_o = 4'b1111;
        endcase
        if (!(istekte_c && islem_q[3])) mem_maske_o = 4'b0000;
    end

    always_comb begin
        durum_d   = durum_q;
        adres_d   = adres_q;
        veri_d    = veri_q;
        islem_d   = islem_q;
        rd_d      = rd_q;
        gecerli_d = tut_c ? gecerli_q : 1'b0;
        sonuc_d   = sonuc_q;
        rd_o_d    = rd_o_q;
        yaz_d     = yaz_q;
        hizasiz_d = hizasiz_q;
`ifdef BELLEK_ZAMAN_ASIMI_EN
        sayac_d   = sayac_q;
        zaman_d   = zaman_q;
`endif
        case (durum_q)
            BOSTA: begin
                if (!durdur_i && gecerli_i) begin
                    if (!bellek_i || !hizali_c) begin
                        gecerli_d = 1'b1;
                        sonuc_d   = adres_i;
                        rd_o_d    = rd_i;
                        yaz_d     = !bellek_i && (rd_i != '0);
                        hizasiz_d = bellek_i;
`ifdef BELLEK_ZAMAN_ASIMI_EN
                        zaman_d   = 1'b0;
`endif
                    end else begin
                        adres_d = adres_i;
                        veri_d  = veri_i;
                        islem_d = islem_i;
                        rd_d    = rd_i;
                        durum_d = ISTEK;
`ifdef BELLEK_ZAMAN_ASIMI_EN
                        sayac_d = '0;
`endif
                    end
                end
            end
            ISTEK: begin
                if (aktarim_c) begin
                    durum_d   = BOSTA;
                    gecerli_d = 1'b1;
                    sonuc_d   = islem_q[3] ? adres_q : yuk_c;
                    rd_o_d    = rd_q;
                    yaz_d     = !islem_q[3] && (rd_q != '0);
                    hizasiz_d = 1'b0;
`ifdef BELLEK_ZAMAN_ASIMI_EN
                    zaman_d   = 1'b0;
                end else if (sayac_q == ZAMAN_SINIRI) begin
                    // Abort only once the result registers are free to take the error.
                    if (!tut_c) begin
                        durum_d   = BOSTA;
                        gecerli_d = 1'b1;
                        sonuc_d   = adres_q;
                        rd_o_d    = rd_q;
                        yaz_d     = 1'b0;
                        hizasiz_d = 1'b0;
                        zaman_d   = 1'b1;
                    end
                end else begin
                    sayac_d = sayac_q + SAYAC_W'(1);
`endif
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BOSTA;
            adres_q   <= '0;
            veri_q    <= '0;
            islem_q   <= '0;
            rd_q      <= '0;
            gecerli_q <= 1'b0;
            sonuc_q   <= '0;
            rd_o_q    <= '0;
            yaz_q     <= 1'b0;
            hizasiz_q <= 1'b0;
`ifdef BELLEK_ZAMAN_ASIMI_EN
            sayac_q   <= '0;
            zaman_q   <= 1'b0;
`endif
        end else begin
            durum_q   <= durum_d;
            adres_q   <= adres_d;
            veri_q    <= veri_d;
            islem_q   <= islem_d;
            rd_q      <= rd_d;
            gecerli_q <= gecerli_d;
            sonuc_q   <= sonuc_d;
            rd_o_q    <= rd_o_d;
            yaz_q     <= yaz_d;
            hizasiz_q <= hizasiz_d;
`ifdef BELLEK_ZAMAN_ASIMI_EN
            sayac_q   <= sayac_d;
            zaman_q   <= zaman_d;
`endif
        end
    end

    assign mem_istek_o = istekte_c && !durdur_i;
    assign mem_yaz_o   = istekte_c && islem_q[3];
    assign mem_adres_o = {adres_q[31:2], 2'b00};
    assign durdur_o    = istekte_c;
    assign gecerli_o   = gecerli_q;
    assign sonuc_o     = sonuc_q;
    assign rd_o        = rd_o_q;
    assign yaz_o       = yaz_q;
`ifdef BELLEK_ZAMAN_ASIMI_EN
    assign hata_o      = {zaman_q, hizasiz_q};
`else
    assign hata_o      = {1'b0, hizasiz_q};
`endif

endmodule

// File: tb/tb_bellek_erisim.sv
// Directed self-checking bench for bellek_erisim (default build, no timeout feature).
module tb_bellek_erisim;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        durdur_i, gecerli_i, bellek_i;
    logic [3:0]  islem_i;
    logic [31:0] adres_i, veri_i;
    logic [4:0]  rd_i;
    logic        mem_istek_o, mem_yaz_o;
    logic [31:0] mem_adres_o, mem_veri_o;
    logic [3:0]  mem_maske_o;
    logic        mem_hazir_i;
    logic [31:0] mem_veri_i;
    logic        gecerli_o;
    logic [31:0] sonuc_o;
    logic [4:0]  rd_o;
    logic        yaz_o;
    logic [1:0]  hata_o;
    logic        durdur_o;

    int n_assert = 0;
    int n_fail   = 0;

    bellek_erisim dut (
        .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i), .gecerli_i(gecerli_i),
        .bellek_i(bellek_i), .islem_i(islem_i), .adres_i(adres_i), .veri_i(veri_i),
        .rd_i(rd_i), .mem_istek_o(mem_istek_o), .mem_yaz_o(mem_yaz_o),
        .mem_adres_o(mem_adres_o), .mem_veri_o(mem_veri_o), .mem_maske_o(mem_maske_o),
        .mem_hazir_i(mem_hazir_i), .mem_veri_i(mem_veri_i), .gecerli_o(gecerli_o),
        .sonuc_o(sonuc_o), .rd_o(rd_o), .yaz_o(yaz_o), .hata_o(hata_o), .durdur_o(durdur_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic g, input logic b, input logic [3:0] isl,
                      input logic [31:0] a, input logic [31:0] v, input logic [4:0] r);
        gecerli_i = g; bellek_i = b; islem_i = isl; adres_i = a; veri_i = v; rd_i = r;
    endtask

    initial begin
        rst_i = 1'b0; durdur_i = 1'b0; mem_hazir_i = 1'b0; mem_veri_i = '0;
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        chk("rst_gecerli", 32'(gecerli_o), 32'h0);
        chk("rst_durdur",  32'(durdur_o), 32'h0);
        chk("rst_istek",   32'(mem_istek_o), 32'h0);
        chk("rst_hata",    32'(hata_o), 32'h0);
        chk("rst_sonuc",   sonuc_o, 32'h0);

        // Release and accept an ADD pass-through on the very next edge.
        rst_i = 1'b1;
        op(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 5'd5);
        tick();
        chk("add_gecerli", 32'(gecerli_o), 32'h1);
        chk("add_sonuc",   sonuc_o, 32'h10);
        chk("add_rd",      32'(rd_o), 32'd5);
        chk("add_yaz",     32'(yaz_o), 32'h1);
        chk("add_durdur",  32'(durdur_o), 32'h0);
        op(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, 5'd0);
        tick();
        chk("rd0_yaz",     32'(yaz_o), 32'h0);
        chk("rd0_sonuc",   sonuc_o, 32'h44);
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("bos_gecerli", 32'(gecerli_o), 32'h0);

        // LB at 0x1003, memory ready on the third ISTEK cycle.
        op(1'b1, 1'b1, 4'b0000, 32'h0000_1003, 32'h0, 5'd7);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        chk("lb_durdur",   32'(durdur_o), 32'h1);
        chk("lb_istek",    32'(mem_istek_o), 32'h1);
        chk("lb_adres",    mem_adres_o, 32'h0000_1000);
        chk("lb_yaz",      32'(mem_yaz_o), 32'h0);
        tick(); tick();
        chk("lb_bekle",    32'(durdur_o), 32'h1);
        chk("lb_bekle_g",  32'(gecerli_o), 32'h0);
        mem_hazir_i = 1'b1; mem_veri_i = 32'h80FF_1234;
        tick();
        mem_hazir_i = 1'b0;
        chk("lb_gecerli",  32'(gecerli_o), 32'h1);
        chk("lb_sonuc",    sonuc_o, 32'hFFFF_FF80);
        chk("lb_rd",       32'(rd_o), 32'd7);
        chk("lb_yaz_o",    32'(yaz_o), 32'h1);
        chk("lb_bitti",    32'(durdur_o), 32'h0);

        // LBU of the same byte, minimum latency.
        op(1'b1, 1'b1, 4'b0100, 32'h0000_1003, 32'h0, 5'd7);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        mem_hazir_i = 1'b1;
        tick();
        mem_hazir_i = 1'b0;
        chk("lbu_sonuc",   sonuc_o, 32'h0000_0080);

        // LH at lane 2 (sign), LHU at lane 0, LW.
        op(1'b1, 1'b1, 4'b0001, 32'h0000_2002, 32'h0, 5'd8);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        mem_hazir_i = 1'b1;
        tick();
        chk("lh_sonuc",    sonuc_o, 32'hFFFF_80FF);
        op(1'b1, 1'b1, 4'b0101, 32'h0000_4000, 32'h0, 5'd8);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("lhu_sonuc",   sonuc_o, 32'h0000_1234);
        op(1'b1, 1'b1, 4'b0010, 32'h0000_4004, 32'h0, 5'd9);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        tick();
        mem_hazir_i = 1'b0;
        chk("lw_sonuc",    sonuc_o, 32'h80FF_1234);
        chk("lw_rd",       32'(rd_o), 32'd9);

        // SH at 0x2002; downstream stall gates the request.
        op(1'b1, 1'b1, 4'b1001, 32'h0000_2002, 32'h0000_ABCD, 5'd3);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        chk("sh_maske",    32'(mem_maske_o), 32'b1100);
        chk("sh_veri",     mem_veri_o, 32'hABCD_ABCD);
        chk("sh_yaz",      32'(mem_yaz_o), 32'h1);
        chk("sh_adres",    mem_adres_o, 32'h0000_2000);
        durdur_i = 1'b1; mem_hazir_i = 1'b1;
        #1;
        chk("sh_durdur_istek", 32'(mem_istek_o), 32'h0);
        tick();
        chk("sh_durdur_bekle", 32'(durdur_o), 32'h1);
        durdur_i = 1'b0;
        tick();
        mem_hazir_i = 1'b0;
        chk("sh_gecerli",  32'(gecerli_o), 32'h1);
        chk("sh_yaz_o",    32'(yaz_o), 32'h0);

        // SB lane 1 and SW masks/data.
        op(1'b1, 1'b1, 4'b1000, 32'h0000_5001, 32'h1234_5678, 5'd0);
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        chk("sb_maske",    32'(mem_maske_o), 32'b0010);
        chk("sb_veri",     mem_veri_o, 32'h7878_7878);
        mem_hazir_i = 1'b1;
        tick();
        op(1'b1, 1'b1, 4'b1010, 32'h0000_5008, 32'hCAFE_F00D, 5'd0);
        mem_hazir_i = 1'b0;
        tick();
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        chk("sw_maske",    32'(mem_maske_o), 32'b1111);
        chk("sw_veri",     mem_veri_o, 32'hCAFE_F00D);
        mem_hazir_i = 1'b1;
        tick();
        mem_hazir_i = 1'b0;

        // Misaligned LW and LH.
        op(1'b1, 1'b1, 4'b0010, 32'h0000_3001, 32'h0, 5'd4);
        #1;
        chk("lw_hiz_istek", 32'(mem_istek_o), 32'h0);
        tick();
        chk("lw_hiz_istek2", 32'(mem_istek_o), 32'h0);
        chk("lw_hiz_durdur", 32'(durdur_o), 32'h0);
        chk("lw_hiz_g",    32'(gecerli_o), 32'h1);
        chk("lw_hiz_hata", 32'(hata_o), 32'b01);
        chk("lw_hiz_yaz",  32'(yaz_o), 32'h0);
        chk("lw_hiz_sonuc", sonuc_o, 32'h0000_3001);
        op(1'b1, 1'b1, 4'b0001, 32'h0000_3003, 32'h0, 5'd4);
        tick();
        chk("lh_hiz_hata", 32'(hata_o), 32'b01);
        chk("lh_hiz_durdur", 32'(durdur_o), 32'h0);

        // Output hold under downstream stall; new op not accepted meanwhile.
        op(1'b1, 1'b0, 4'h0, 32'h0000_00AA, 32'h0, 5'd6);
        tick();
        chk("tut_hata0",   32'(hata_o), 32'b00);
        durdur_i = 1'b1;
        op(1'b1, 1'b0, 4'h0, 32'h0000_00BB, 32'h0, 5'd2);
        tick(); tick();
        chk("tut_gecerli", 32'(gecerli_o), 32'h1);
        chk("tut_sonuc",   sonuc_o, 32'h0000_00AA);
        chk("tut_rd",      32'(rd_o), 32'd6);
        durdur_i = 1'b0;
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("tut_birak",   32'(gecerli_o), 32'h0);

        // Async reset in the 2nd ISTEK cycle, then the held op is accepted.
        op(1'b1, 1'b1, 4'b0010, 32'h0000_4000, 32'h0, 5'd9);
        tick();
        op(1'b1, 1'b0, 4'h0, 32'h0000_0077, 32'h0, 5'd4);
        tick();
        chk("rst2_istek_once", 32'(mem_istek_o), 32'h1);
        rst_i = 1'b0;
        #1;
        chk("rst2_istek",  32'(mem_istek_o), 32'h0);
        chk("rst2_durdur", 32'(durdur_o), 32'h0);
        chk("rst2_maske",  32'(mem_maske_o), 32'h0);
        chk("rst2_adres",  mem_adres_o, 32'h0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("rst2_kabul_g", 32'(gecerli_o), 32'h1);
        chk("rst2_kabul_s", sonuc_o, 32'h0000_0077);
        chk("rst2_kabul_d", 32'(durdur_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bellek_erisim.md
BELLEK_ERISIM -- requirements
Module: bellek_erisim

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk_i in, 1 bit, single clock, all state on its rising edge; rst_i in, 1 bit, asynchronous reset, active-low.
REQ-002 The block SHALL have input durdur_i, 1 bit: downstream (writeback) stall.
REQ-003 The block SHALL have input gecerli_i, 1 bit: the execute-stage result is valid (driven by the execute stage's ready output).
REQ-004 The block SHALL have input bellek_i, 1 bit: the operation is a load or store.
REQ-005 The block SHALL have input islem_i, 4 bits: {store, funct3}, with funct3 values LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-006 The block SHALL have input adres_i, 32 bits: the execute-stage result; this is the effective address for memory ops and the pass-through value otherwise.
REQ-007 The block SHALL have input veri_i, 32 bits: store data (rs2).
REQ-008 The block SHALL have input rd_i, 5 bits: destination register; 0 means no write.
REQ-009 The block SHALL have output mem_istek_o, 1 bit: data-memory request.
REQ-010 The block SHALL have output mem_yaz_o, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have output mem_adres_o, 32 bits: word address, {adres[31:2], 2'b00}.
REQ-012 The block SHALL have output mem_veri_o, 32 bits: store data, lane-replicated.
REQ-013 The block SHALL have output mem_maske_o, 4 bits: byte write enables.
REQ-014 The block SHALL have input mem_hazir_i, 1 bit: memory completes the transfer.
REQ-015 The block SHALL have input mem_veri_i, 32 bits: read word; valid only when mem_hazir_i=1.
REQ-016 The block SHALL have outputs gecerli_o (1 bit), sonuc_o (32 bits), rd_o (5 bits) and yaz_o (1 bit): the registered writeback result and register-write enable.
REQ-017 The block SHALL have output hata_o, 2 bits: 01 = misaligned access, 10 = memory timeout, 00 = no error.
REQ-018 The block SHALL have output durdur_o, 1 bit: upstream stall, defined as (state == ISTEK).

Function
REQ-019 The FSM SHALL have exactly two states, BOSTA and ISTEK.
REQ-020 In BOSTA with gecerli_i=1, bellek_i=0 and durdur_i=0, the block SHALL at the next edge set gecerli_o=1, sonuc_o=adres_i, rd_o=rd_i, yaz_o=(rd_i!=0), hata_o=00 (1-cycle latency).
REQ-021 Alignment SHALL be: LW/SW need adres[1:0]=00; LH/LHU/SH need adres[0]=0; byte ops are always aligned.
REQ-022 A misaligned memory op in BOSTA SHALL issue no request and SHALL at the next edge set gecerli_o=1, hata_o=01, yaz_o=0, sonuc_o=adres_i.
REQ-023 An aligned memory op in BOSTA with durdur_i=0 SHALL latch the address, data, islem and rd, and SHALL enter ISTEK.
REQ-024 In ISTEK the block SHALL hold mem_istek_o = !durdur_i, with mem_adres_o, mem_yaz_o, mem_veri_o and mem_maske_o stable.
REQ-025 A transfer SHALL occur on an edge where mem_istek_o=1 and mem_hazir_i=1; at that edge the block SHALL return to BOSTA and load the output registers.
REQ-026 Store results SHALL be gecerli_o=1, yaz_o=0.
REQ-027 Load results SHALL set sonuc_o from lane = adres[1:0]: LB/LBU take byte[lane], sign- or zero-extended; LH/LHU take the half at lane[1], sign- or zero-extended; LW takes the whole word.
REQ-028 Store byte lanes SHALL be: SB mem_maske_o=0001<<lane, data = byte replicated x4; SH mask=0011<<adres[1:0], data = half replicated x2; SW mask=1111.
REQ-029 When gecerli_o=1 and durdur_i=1, the output registers SHALL hold; otherwise gecerli_o SHALL clear one cycle after presentation unless a new result is loaded.
REQ-030 When gecerli_i=0 in BOSTA, the block SHALL load gecerli_o=0 at the next edge when durdur_i=0.
REQ-031 Minimum load/store latency SHALL be 2 cycles: the accept edge, then ISTEK with mem_hazir_i=1 on the first cycle.
REQ-032 Stall timing: upstream holds its next instruction while durdur_o=1; that instruction SHALL be accepted in the first BOSTA cycle.

Reset
REQ-033 On rst_i=0 the block SHALL immediately enter BOSTA, including mid-request; mem_istek_o, mem_yaz_o, gecerli_o, yaz_o and durdur_o SHALL be 0, hata_o=00, and all data outputs SHALL be 0.
REQ-034 Leaving reset SHALL be synchronous to clk_i, and the first acceptance SHALL be possible in the first cycle after deassertion.

Configuration
REQ-035 With BELLEK_ZAMAN_ASIMI_EN defined, an 8-bit counter SHALL clear on ISTEK entry and increment each ISTEK cycle without a transfer; at 255 the block SHALL abort to BOSTA, deassert mem_istek_o, and present gecerli_o=1, hata_o=10, yaz_o=0.
REQ-036 Without BELLEK_ZAMAN_ASIMI_EN, the block SHALL have no counter, SHALL wait in ISTEK indefinitely, and hata_o[1] SHALL be tied to 0.

Verification
REQ-037 ADD pass-through: adres_i=0x00000010, rd_i=5 -> next cycle gecerli_o=1, sonuc_o=0x10, rd_o=5, yaz_o=1, durdur_o never asserted.
REQ-038 LB: adres_i=0x1003, mem_veri_i=0x80FF1234, mem_hazir_i after 3 cycles -> mem_adres_o=0x1000, sonuc_o=0xFFFFFF80; LBU of the same -> 0x00000080.
REQ-039 SH: adres_i=0x2002, veri_i=0x0000ABCD -> mem_maske_o=1100, mem_veri_o=0xABCDABCD, mem_yaz_o=1, yaz_o=0.
REQ-040 LW at 0x3001 -> no mem_istek_o, hata_o=01, yaz_o=0 after 1 cycle.
REQ-041 rst_i pulsed low in the 2nd ISTEK cycle -> mem_istek_o=0 and durdur_o=0 immediately; the held upstream op is accepted after release.
REQ-042 With BELLEK_ZAMAN_ASIMI_EN, mem_hazir_i held 0 -> abort after 255 ISTEK cycles with hata_o=10; durdur_i=1 during completion -> outputs held until release.
